// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine: FSM state encoding and
// per-operation algorithm select.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_BIN = 1'b1;

endpackage

// File: rtl/gcd_engine_if.sv
// Operand/result handshake bundle between a producer/consumer and gcd_engine.
interface gcd_engine_if #(
  parameter int WIDTH = 16,
  parameter int CW    = WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd;
  logic [CW-1:0]    iter;
  logic             busy;

  modport master (
    output in_valid, mode, a_in, b_in, out_ready,
    input  in_ready, out_valid, gcd, iter, busy
  );

  modport slave (
    input  in_valid, mode, a_in, b_in, out_ready,
    output in_ready, out_valid, gcd, iter, busy
  );
endinterface

// File: rtl/gcd_step.sv
// One combinational reduction step of either subtractive Euclid or binary
// (Stein) GCD, plus the shared termination test.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] next_a,
  output logic [WIDTH-1:0] next_b,
  output logic             inc_k,
  output logic             term
);

  logic             a_gt_b;
  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] diff_ba;

  assign a_gt_b  = (a > b);
  assign diff_ab = a - b;
  assign diff_ba = b - a;
  assign term    = (a == b) || (a == '0) || (b == '0);

  always_comb begin
    next_a = a;
    next_b = b;
    inc_k  = 1'b0;
    case (mode)
      MODE_SUB: begin
        // larger operand is always the minuend, so no underflow
        if (a_gt_b) next_a = diff_ab;
        else        next_b = diff_ba;
      end
      MODE_BIN: begin
        case ({a[0], b[0]})
          2'b00: begin
            next_a = a >> 1;
            next_b = b >> 1;
            inc_k  = 1'b1;
          end
          2'b01: next_a = a >> 1;
          2'b10: next_b = b >> 1;
          default: begin
            // odd - odd is even, so fold the halving into the same step
            if (a_gt_b) next_a = diff_ab >> 1;
            else        next_b = diff_ba >> 1;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gcd_engine.sv
// Handshaked iterative GCD: accepts an operand pair, reduces one step per
// cycle in CALC, and presents gcd/iter in DONE until the consumer takes it.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = WIDTH
) (
  input logic        clk,
  input logic        rst_n,
  gcd_engine_if.slave io
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r, b_r, gcd_r;
  logic [CW-1:0]    k_r, iter_r;
  logic             mode_r;

  logic [WIDTH-1:0] next_a, next_b;
  logic             inc_k, term;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_r),
    .b      (b_r),
    .mode   (mode_r),
    .next_a (next_a),
    .next_b (next_b),
    .inc_k  (inc_k),
    .term   (term)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      k_r    <= '0;
      mode_r <= MODE_SUB;
      gcd_r  <= '0;
      iter_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.in_valid) begin
            a_r    <= io.a_in;
            b_r    <= io.b_in;
            mode_r <= io.mode;
            k_r    <= '0;
            iter_r <= '0;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (term) begin
            // common power of two factored out by the binary mode is restored here
            gcd_r <= ((a_r == '0) ? b_r : a_r) << k_r;
            state <= S_DONE;
          end else begin
            a_r <= next_a;
            b_r <= next_b;
            if (inc_k)         k_r    <= k_r + 1'b1;
            if (iter_r != '1)  iter_r <= iter_r + 1'b1;
          end
        end
        S_DONE: begin
          if (io.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == S_IDLE);
  assign io.busy      = (state == S_CALC);
  assign io.out_valid = (state == S_DONE);
  assign io.gcd       = gcd_r;
  assign io.iter      = iter_r;

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed corners plus random operands
// checked against a plain-arithmetic reference model.
module tb_gcd_engine;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gcd_engine_if #(.WIDTH(W), .CW(W)) bus ();

  gcd_engine #(.WIDTH(W), .CW(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // gcd by Euclid's remainder method; step count from the per-mode reduction rules
  function automatic void ref_gcd(input bit m, input int unsigned a0, input int unsigned b0,
                                  output int unsigned g, output int unsigned steps);
    int unsigned x, y, t;
    x = a0; y = b0;
    while (y != 0) begin t = x % y; x = y; y = t; end
    g = x;
    x = a0; y = b0; steps = 0;
    while (!(x == y || x == 0 || y == 0)) begin
      if (!m) begin
        if (x > y) x = x - y; else y = y - x;
      end else if (x % 2 == 0 && y % 2 == 0) begin
        x = x / 2; y = y / 2;
      end else if (x % 2 == 0) x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x > y) x = (x - y) / 2;
      else y = (y - x) / 2;
      steps++;
    end
    if (steps > (1 << W) - 1) steps = (1 << W) - 1;
  endfunction

  // accept one operand pair and wait (bounded) for out_valid; lat = cycles after accept
  task automatic start_op(input bit m, input int unsigned a, input int unsigned b,
                          input int budget, output int lat, output bit timed_out);
    int guard = 0;
    while (!bus.in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    bus.mode = m; bus.a_in = W'(a); bus.b_in = W'(b); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.mode = ~m;
    bus.a_in = W'($urandom); bus.b_in = W'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < budget) begin @(posedge clk); #1; lat++; end
    timed_out = !bus.out_valid;
    if (timed_out) begin
      rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.gcd !== '0) begin errors++; $display("FAIL reset_gcd got %0d want 0", bus.gcd); end
    checks++; if (bus.iter !== '0) begin errors++; $display("FAIL reset_iter got %0d want 0", bus.iter); end
  endtask

  task automatic test_directed();
    // mode, a, b, gcd, iter
    int unsigned tbl [4][5] = '{'{0, 17, 10, 1, 6}, '{0, 48, 18, 6, 4},
                                '{1, 48, 18, 6, 5}, '{1, 65535, 1, 1, 15}};
    int lat; bit to;
    int unsigned g_m, s_m;
    foreach (tbl[i]) begin
      start_op(tbl[i][0][0], tbl[i][1], tbl[i][2], int'(tbl[i][4]) + 20, lat, to);
      checks++; if (bus.gcd !== W'(tbl[i][3])) begin errors++; $display("FAIL dir%0d_gcd got %0d want %0d", i, bus.gcd, tbl[i][3]); end
      checks++; if (bus.iter !== W'(tbl[i][4])) begin errors++; $display("FAIL dir%0d_iter got %0d want %0d", i, bus.iter, tbl[i][4]); end
      checks++; if (lat != int'(tbl[i][4]) + 1) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, tbl[i][4] + 1); end
      if (!to) finish_op();
    end
    // binary mode must beat subtractive on (65535,1)
    ref_gcd(1'b0, 65535, 1, g_m, s_m);
    checks++; if (!(32'(bus.iter) < s_m)) begin errors++; $display("FAIL bin_faster got iter %0d want < %0d", bus.iter, s_m); end
  endtask

  task automatic test_corners();
    int unsigned tbl [4][3] = '{'{0, 25, 25}, '{40, 0, 40}, '{0, 0, 0}, '{9, 9, 9}};
    int lat; bit to;
    for (int m = 0; m < 2; m++) begin
      foreach (tbl[i]) begin
        start_op(m[0], tbl[i][0], tbl[i][1], 10, lat, to);
        checks++; if (bus.gcd !== W'(tbl[i][2])) begin errors++; $display("FAIL corner_m%0d_%0d_gcd got %0d want %0d", m, i, bus.gcd, tbl[i][2]); end
        checks++; if (bus.iter !== '0) begin errors++; $display("FAIL corner_m%0d_%0d_iter got %0d want 0", m, i, bus.iter); end
        checks++; if (lat != 1) begin errors++; $display("FAIL corner_m%0d_%0d_latency got %0d want 1", m, i, lat); end
        if (!to) finish_op();
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    start_op(1'b1, 48, 18, 25, lat, to);
    bus.mode = 1'b0; bus.a_in = 16'd100; bus.b_in = 16'd7; bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_out_valid got %b want 1", c, bus.out_valid); end
      checks++; if (bus.gcd !== 16'd6 || bus.iter !== 16'd5) begin errors++; $display("FAIL bp%0d_hold got gcd %0d iter %0d want 6 5", c, bus.gcd, bus.iter); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_in_ready got %b want 0", c, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_turnaround got in_ready %b want 0", bus.in_ready); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got in_ready %b out_valid %b want 1 0", bus.in_ready, bus.out_valid); end
    checks++; if (bus.gcd !== 16'd6 || bus.iter !== 16'd5) begin errors++; $display("FAIL bp_idle_hold got gcd %0d iter %0d want 6 5", bus.gcd, bus.iter); end
  endtask

  task automatic test_reset_mid();
    int lat; bit to;
    int unsigned g_m, s_m;
    bus.mode = 1'b0; bus.a_in = 16'd1000; bus.b_in = 16'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b want 1", bus.busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl got in_ready %b busy %b out_valid %b want 1 0 0", bus.in_ready, bus.busy, bus.out_valid); end
    checks++; if (bus.gcd !== '0 || bus.iter !== '0) begin errors++; $display("FAIL midrst_regs got gcd %0d iter %0d want 0 0", bus.gcd, bus.iter); end
    ref_gcd(1'b0, 12, 8, g_m, s_m);
    start_op(1'b0, 12, 8, 20, lat, to);
    checks++; if (bus.gcd !== 16'd4) begin errors++; $display("FAIL midrst_after_gcd got %0d want 4", bus.gcd); end
    checks++; if (32'(bus.iter) != s_m) begin errors++; $display("FAIL midrst_after_iter got %0d want %0d", bus.iter, s_m); end
    if (!to) finish_op();
  endtask

  task automatic test_random();
    int lat; bit to;
    int unsigned a, b, g_m, s_m;
    bit m;
    for (int n = 0; n < 60; n++) begin
      m = 1'($urandom);
      a = m ? $urandom_range(0, 65535) : $urandom_range(0, 400);
      b = m ? $urandom_range(0, 65535) : $urandom_range(0, 400);
      ref_gcd(m, a, b, g_m, s_m);
      start_op(m, a, b, int'(s_m) + 20, lat, to);
      checks++; if (32'(bus.gcd) != g_m || 32'(bus.iter) != s_m || lat != int'(s_m) + 1) begin
        errors++;
        $display("FAIL rand%0d m%0d (%0d,%0d) got gcd %0d iter %0d lat %0d want %0d %0d %0d",
                 n, m, a, b, bus.gcd, bus.iter, lat, g_m, s_m, s_m + 1);
      end
      if (!to) finish_op();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.mode = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
